// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, capture-state type and segment decode table
// for the 7-segment scan reader. Patterns are listed a..g, active-low,
// so index 0 of a seg_t is segment a.
package seg7_pkg;
    localparam int SEG_W = 7;
    typedef logic [0:SEG_W-1] seg_t;
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} cap_state_e;
    localparam seg_t SEG7_DECODE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: reverse lookup of an active-low a..g pattern to a hex nibble.
//   seg_n_i   in  [0:6] segments a..g, active-low
//   nibble_o  out [3:0] decoded value, 0 when the pattern is not a hex glyph
//   illegal_o out       pattern matched no table entry
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [0:SEG_W-1] seg_n_i,
    output logic [3:0]       nibble_o,
    output logic             illegal_o
);
    always_comb begin
        nibble_o  = '0;
        illegal_o = 1'b1;
        for (int i = 0; i < 16; i++)
            if (seg_n_i == SEG7_DECODE[i]) begin
                nibble_o  = 4'(i);
                illegal_o = 1'b0;
            end
    end
endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers the hex frame shown on a multiplexed active-low
// 7-segment bus and hands it out with a valid/ready handshake.
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   seg_n_i [0:6]         segments a..g, active-low
//   dig_n_i [NDIG]        digit selects, active-low
//   out_ready_i           consumer accepts when out_valid_o is high
//   out_value_o [4*NDIG]  decoded frame, digit k in [4k+3:4k]
//   out_err_o [NDIG]      digit k showed an unrecognised pattern
//   out_valid_o           frame available
//   overflow_o            sticky: a completed frame was dropped
// Optional macro SEG7_DP_EN adds dp_n_i (decimal point, active-low) and out_dp_o [NDIG].
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [0:SEG_W-1]  seg_n_i,
    input  logic [NDIG-1:0]   dig_n_i,
`ifdef SEG7_DP_EN
    input  logic              dp_n_i,
    output logic [NDIG-1:0]   out_dp_o,
`endif
    input  logic              out_ready_i,
    output logic [4*NDIG-1:0] out_value_o,
    output logic [NDIG-1:0]   out_err_o,
    output logic              out_valid_o,
    output logic              overflow_o
);
    localparam int CW = $clog2(STABLE_CYC + 1);
    // The decimal point, when present, rides in the low bit of the synchronised pin bus
    // so it takes part in the stability comparison for free.
`ifdef SEG7_DP_EN
    localparam int PW = SEG_W + 1;
    logic [PW-1:0] pin;
    assign pin = {seg_n_i, dp_n_i};
`else
    localparam int PW = SEG_W;
    logic [PW-1:0] pin;
    assign pin = seg_n_i;
`endif
    logic [PW-1:0]     pin_s1_q, pin_s2_q, pin_prev_q;
    logic [NDIG-1:0]   dig_s1_q, dig_s2_q, dig_prev_q;
    cap_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, run;
    logic [NDIG-1:0]   mask_q, mask_d, err_q, err_d, out_err_q, out_err_d, sel;
    logic [4*NDIG-1:0] val_q, val_d, out_value_q, out_value_d;
    logic              out_valid_q, out_valid_d, overflow_q, overflow_d;
    logic              sample_ok, same, keep, cap, done, load;
    logic [0:SEG_W-1]  seg_s;
    logic [3:0]        nibble;
    logic              illegal;

    assign seg_s = pin_s2_q[PW-1 -: SEG_W];

    seg7_pattern_decode u_dec (
        .seg_n_i   (seg_s),
        .nibble_o  (nibble),
        .illegal_o (illegal)
    );

    always_comb begin
        sel        = ~dig_s2_q;
        sample_ok  = $onehot(sel);
        same       = {pin_s2_q, dig_s2_q} == {pin_prev_q, dig_prev_q};
        // An unchanged sample while holding must not capture again.
        keep       = state_q == HOLD && same;
        run        = (state_q == SETTLE && same) ? cnt_q + CW'(1) : CW'(1);
        cap        = sample_ok && !keep && run == CW'(STABLE_CYC);
        state_d    = !sample_ok ? IDLE : (keep || cap) ? HOLD : SETTLE;
        cnt_d      = !sample_ok ? '0 : keep ? cnt_q : run;
        done       = cap && &(mask_q | sel);
        mask_d     = done ? '0 : cap ? mask_q | sel : mask_q;
        load       = done && (!out_valid_q || out_ready_i);
        val_d      = val_q;
        err_d      = err_q;
        for (int k = 0; k < NDIG; k++)
            if (cap && sel[k]) begin
                val_d[4*k +: 4] = nibble;
                err_d[k]        = illegal;
            end
        out_value_d = load ? val_d : out_value_q;
        out_err_d   = load ? err_d : out_err_q;
        out_valid_d = load || (out_valid_q && !out_ready_i);
        overflow_d  = overflow_q || (done && out_valid_q && !out_ready_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pin_s1_q    <= '1;
            pin_s2_q    <= '1;
            pin_prev_q  <= '1;
            dig_s1_q    <= '1;
            dig_s2_q    <= '1;
            dig_prev_q  <= '1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            mask_q      <= '0;
            val_q       <= '0;
            err_q       <= '0;
            out_value_q <= '0;
            out_err_q   <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            pin_s1_q    <= pin;
            pin_s2_q    <= pin_s1_q;
            pin_prev_q  <= pin_s2_q;
            dig_s1_q    <= dig_n_i;
            dig_s2_q    <= dig_s1_q;
            dig_prev_q  <= dig_s2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            val_q       <= val_d;
            err_q       <= err_d;
            out_value_q <= out_value_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_value_o = out_value_q;
    assign out_err_o   = out_err_q;
    assign out_valid_o = out_valid_q;
    assign overflow_o  = overflow_q;

`ifdef SEG7_DP_EN
    logic [NDIG-1:0] dp_q, dp_d, out_dp_q;
    always_comb begin
        dp_d = dp_q;
        for (int k = 0; k < NDIG; k++)
            if (cap && sel[k]) dp_d[k] = ~pin_s2_q[0];
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dp_q     <= '0;
            out_dp_q <= '0;
        end else begin
            dp_q     <= dp_d;
            out_dp_q <= load ? dp_d : out_dp_q;
        end
    end
    assign out_dp_o = out_dp_q;
`endif
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: table-driven frames, hand sequences and random bus traffic,
// all checked against a run-length reference model of the scan reader.
`timescale 1ns/1ps
module tb_seg7_scan_reader;
    localparam int NDIG = 4;
    localparam int S    = 4;

    logic clk = 0;
    logic rst_n = 0;
    logic [6:0] seg_n = '1;
    logic [NDIG-1:0] dig_n = '1;
    logic dp_n = 1;
    logic rdy = 1;
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0] err, dpo;
    logic valid, ovf;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    seg7_scan_reader #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .seg_n_i(seg_n),
        .dig_n_i(dig_n),
`ifdef SEG7_DP_EN
        .dp_n_i(dp_n),
        .out_dp_o(dpo),
`endif
        .out_ready_i(rdy),
        .out_value_o(value),
        .out_err_o(err),
        .out_valid_o(valid),
        .overflow_o(ovf)
    );
`ifndef SEG7_DP_EN
    assign dpo = '0;
`endif

    logic [6:0] tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [4:0] dec(logic [6:0] p);
        for (int i = 0; i < 16; i++) if (tbl[i] == p) return {1'b0, 4'(i)};
        return 5'b10000;
    endfunction

    function automatic int low_count(logic [NDIG-1:0] d);
        int n = 0;
        for (int i = 0; i < NDIG; i++) n += int'(!d[i]);
        return n;
    endfunction

    // Reference model: sample seen by the capture logic is the pin value two edges old;
    // a digit is captured when its run of identical valid samples reaches exactly S.
    typedef logic [NDIG+7:0] smp_t;
    smp_t h1, h2, last, cur;
    int run;
    logic m_hs, m_cap, dp_eff;
    logic [4:0] m_dec;
    logic [3:0] m_nib [NDIG];
    logic [NDIG-1:0] m_err, m_dp, m_have, e_err, e_dp;
    logic [4*NDIG-1:0] e_val;
    logic e_valid, e_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 = '1; h2 = '1; last = '1; run = 0;
            m_err = '0; m_dp = '0; m_have = '0;
            for (int k = 0; k < NDIG; k++) m_nib[k] = '0;
            e_val = '0; e_err = '0; e_dp = '0; e_valid = 0; e_ovf = 0;
        end else begin
`ifdef SEG7_DP_EN
            dp_eff = dp_n;
`else
            dp_eff = 1'b1;
`endif
            cur = h2; h2 = h1; h1 = {dp_eff, dig_n, seg_n};
            m_hs = e_valid && rdy;
            m_cap = 0;
            if (low_count(cur[NDIG+6:7]) == 1) begin
                run = (run > 0 && cur == last) ? run + 1 : 1;
                m_cap = (run == S);
            end else run = 0;
            last = cur;
            if (m_cap) begin
                m_dec = dec(cur[6:0]);
                for (int k = 0; k < NDIG; k++)
                    if (!cur[7+k]) begin
                        m_nib[k] = m_dec[3:0];
                        m_err[k] = m_dec[4];
                        m_dp[k] = !cur[NDIG+7];
                        m_have[k] = 1;
                    end
                if (&m_have) begin
                    m_have = '0;
                    if (!e_valid || rdy) begin
                        for (int k = 0; k < NDIG; k++) e_val[4*k +: 4] = m_nib[k];
                        e_err = m_err; e_dp = m_dp; e_valid = 1; m_hs = 0;
                    end else e_ovf = 1;
                end
            end
            if (m_hs) e_valid = 0;
        end
    end

    logic got;
    logic [15:0] got_val;
    logic [3:0] got_err, got_dp;
    int nv;

    task automatic chk(string name, logic [31:0] a, logic [31:0] w);
        total++;
        if (a !== w) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, a, w);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
        total++;
        if ({valid, ovf, err, value, dpo} !== {e_valid, e_ovf, e_err, e_val, e_dp}) begin
            bad++;
            $display("FAIL model t=%0t got v=%b o=%b e=%b val=%h dp=%b want v=%b o=%b e=%b val=%h dp=%b",
                     $time, valid, ovf, err, value, dpo, e_valid, e_ovf, e_err, e_val, e_dp);
        end
        if (valid && rdy) begin
            got = 1; got_val = value; got_err = err; got_dp = dpo; nv++;
        end
    endtask

    task automatic show(logic [6:0] p, int k, logic d, int n);
        seg_n = p; dig_n = ~(NDIG'(1) << k); dp_n = !d;
        repeat (n) cyc();
    endtask

    task automatic idle(int n);
        seg_n = '1; dig_n = '1; dp_n = 1;
        repeat (n) cyc();
    endtask

    task automatic reset_pulse();
        rst_n = 0;
        cyc();
        rst_n = 1;
    endtask

    typedef struct {
        logic [NDIG-1:0][6:0] p;
        logic [NDIG-1:0] dpm;
        logic [15:0] val;
        logic [3:0] e;
        logic [3:0] dp;
    } vec_t;
    vec_t vecs [6];

    initial begin
        vecs[0] = '{p: {tbl[4], tbl[3], tbl[2], tbl[1]}, dpm: 4'b0000, val: 16'h4321, e: 4'b0000, dp: 4'b0000};
        vecs[1] = '{p: {tbl[8], 7'h7F, tbl[8], tbl[8]}, dpm: 4'b0000, val: 16'h8088, e: 4'b0100, dp: 4'b0000};
        vecs[2] = '{p: {tbl[13], tbl[12], tbl[11], tbl[10]}, dpm: 4'b0000, val: 16'hDCBA, e: 4'b0000, dp: 4'b0000};
        vecs[3] = '{p: {tbl[9], tbl[0], tbl[15], tbl[14]}, dpm: 4'b0000, val: 16'h90FE, e: 4'b0000, dp: 4'b0000};
        vecs[4] = '{p: {tbl[7], tbl[6], tbl[5], 7'b1011100}, dpm: 4'b0000, val: 16'h7650, e: 4'b0001, dp: 4'b0000};
        vecs[5] = '{p: {tbl[3], tbl[2], tbl[1], tbl[0]}, dpm: 4'b1000, val: 16'h3210, e: 4'b0000, dp: 4'b1000};
        got = 0; got_val = 0; got_err = 0; got_dp = 0; nv = 0;

        // reset with random bus activity
        for (int i = 0; i < 10; i++) begin
            seg_n = 7'($urandom); dig_n = NDIG'($urandom); dp_n = 1'($urandom);
            cyc();
        end
        chk("reset_outputs", 32'({valid, ovf, err, value}), 32'h0);
        rst_n = 1;
        idle(8);
        chk("idle_after_reset", 32'({valid, ovf}), 32'h0);

        // table-driven frames
        for (int r = 0; r < 6; r++) begin
            got = 0; nv = 0;
            for (int k = 0; k < NDIG; k++) show(vecs[r].p[k], k, vecs[r].dpm[k], 8);
            idle(6);
            chk("frame_seen", 32'(got), 32'd1);
            chk("frame_value", 32'(got_val), 32'(vecs[r].val));
            chk("frame_err", 32'(got_err), 32'(vecs[r].e));
            chk("valid_one_cycle", 32'(nv), 32'd1);
`ifdef SEG7_DP_EN
            chk("frame_dp", 32'(got_dp), 32'(vecs[r].dp));
`endif
        end

        // digit 1 never stable for S synchronized cycles
        got = 0;
        show(tbl[1], 0, 0, 8);
        show(tbl[5], 1, 0, S - 1);
        show(tbl[6], 1, 0, S - 1);
        show(tbl[2], 2, 0, 8);
        show(tbl[3], 3, 0, 8);
        idle(6);
        chk("unstable_no_frame", 32'(got), 32'd0);
        show(tbl[9], 1, 0, 8);
        idle(6);
        chk("stable_completes", 32'(got), 32'd1);
        chk("stable_value", 32'(got_val), 32'h3291);

        // back-pressure: second frame dropped, first held
        rdy = 0;
        for (int k = 0; k < NDIG; k++) show(vecs[0].p[k], k, 0, 8);
        idle(6);
        chk("held_valid", 32'({valid, ovf}), 32'b10);
        chk("held_value", 32'(value), 32'h4321);
        for (int k = 0; k < NDIG; k++) show(vecs[2].p[k], k, 0, 8);
        idle(6);
        chk("drop_overflow", 32'({valid, ovf}), 32'b11);
        chk("drop_value_kept", 32'(value), 32'h4321);
        rdy = 1;
        cyc();
        chk("accept_drops_valid", 32'({valid, ovf}), 32'b01);
        reset_pulse();
        chk("overflow_reset", 32'(ovf), 32'd0);

        // two digits selected is not a valid sample
        got = 0;
        show(tbl[2], 2, 0, 8);
        show(tbl[3], 3, 0, 8);
        seg_n = tbl[1]; dig_n = 4'b1100;
        repeat (10) cyc();
        idle(6);
        chk("two_low_no_capture", 32'(got), 32'd0);
        show(tbl[5], 0, 0, 8);
        show(tbl[6], 1, 0, 8);
        idle(6);
        chk("mask_kept_value", 32'(got_val), 32'h3265);

        // reset mid-frame discards captured digits
        got = 0;
        for (int k = 0; k < 3; k++) show(vecs[0].p[k], k, 0, 8);
        reset_pulse();
        show(vecs[0].p[3], 3, 0, 8);
        idle(6);
        chk("reset_clears_mask", 32'(got), 32'd0);
        for (int k = 0; k < NDIG; k++) show(vecs[0].p[k], k, 0, 8);
        idle(6);
        chk("full_scan_after_reset", 32'({got, got_val}), 32'h14321);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            int m;
            m = int'($urandom_range(0, 9));
            dig_n = m < 7 ? ~(NDIG'(1) << $urandom_range(0, NDIG - 1)) : m == 7 ? '1 : NDIG'($urandom);
            seg_n = $urandom_range(0, 3) != 0 ? tbl[$urandom_range(0, 15)] : 7'($urandom);
            dp_n = 1'($urandom);
            rdy = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 99) == 0) reset_pulse();
            repeat ($urandom_range(1, 7)) cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
